// File: rtl/adder_sequencer.sv
// adder_sequencer: wide-operand adder built from one 3-bit ripple slice.
// It adds one 3-bit chunk per clock, LSB chunk first, and keeps the
// inter-chunk carry in a register. A start/busy/done handshake launches an
// add and returns sum, carry-out and signed overflow after N_CHUNKS+1 cycles.
// Optional feature macro: ADDER_SEQUENCER_SUB_EN adds a 'sub' input that
// selects A-B (B complemented, carry-in forced to 1).
module adder_sequencer #(
    parameter int N_CHUNKS = 4,
    localparam int W = 3 * N_CHUNKS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
`ifdef ADDER_SEQUENCER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     b_eff;
    logic             cy;
    logic [IDX_W-1:0] idx;
`ifdef ADDER_SEQUENCER_SUB_EN
    logic             sub_q;
`endif

    logic [2:0] slice_a;
    logic [2:0] slice_b;
    logic [2:0] slice_s;
    logic       slice_co;

    // One 3-bit ripple full-adder slice: {carry_out, sum[2:0]}.
    function automatic logic [3:0] full_add3(input logic [2:0] x,
                                             input logic [2:0] y,
                                             input logic       ci);
        logic       c;
        logic [2:0] s;
        c = ci;
        for (int i = 0; i < 3; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Effective B operand: complemented in subtract mode.
    always_comb begin
`ifdef ADDER_SEQUENCER_SUB_EN
        b_eff = sub_q ? ~b_q : b_q;
`else
        b_eff = b_q;
`endif
    end

    // Shared slice, fed the chunk selected by idx and the carry register.
    always_comb begin
        slice_a = a_q[3*idx +: 3];
        slice_b = b_eff[3*idx +: 3];
        {slice_co, slice_s} = full_add3(slice_a, slice_b, cy);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, chunk stepping, and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            cy       <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
`ifdef ADDER_SEQUENCER_SUB_EN
                        sub_q    <= sub;
                        cy       <= sub ? 1'b1 : c_in;
`else
                        cy       <= c_in;
`endif
                        idx      <= '0;
                        sum      <= '0;
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    sum[3*idx +: 3] <= slice_s;
                    cy              <= slice_co;
                    if (idx == LAST_IDX) begin
                        c_out    <= slice_co;
                        // slice_s[2] is the final MSB of the result.
                        overflow <= (a_q[W-1] == b_eff[W-1]) &&
                                    (slice_s[2] != a_q[W-1]);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer (N_CHUNKS=4, W=12).
// Vector table plus randomized operations against an integer reference model,
// and hand-written sequences for mid-run start, reset abort and back-to-back.
module tb_adder_sequencer;

    localparam int N = 4;
    localparam int W = 3 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef ADDER_SEQUENCER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int n_chk  = 0;
    int n_fail = 0;

    adder_sequencer #(.N_CHUNKS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
`ifdef ADDER_SEQUENCER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic. Returns {overflow, c_out, sum}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        logic [W-1:0] ye;
        int           uc;
        int           sx;
        int           sy;
        int           r;
        int           full;
        logic         ov;
        ye   = s ? ~y : y;
        uc   = s ? 1 : int'(ci);
        full = int'(x) + int'(ye) + uc;
        sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy   = ye[W-1] ? int'(ye) - (1 << W) : int'(ye);
        r    = sx + sy + uc;
        ov   = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return {ov, full[W], full[W-1:0]};
    endfunction

    // Launch one add; operands are scrambled after acceptance. With poke set,
    // start is re-asserted (a=0x123) during RUN and must be ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input bit poke, output logic [W-1:0] rs, output logic rc,
                          output logic ro);
        int nbusy;
        bit got;
        rs = '0; rc = 1'b0; ro = 1'b0;
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        nbusy = 0;
        got   = 1'b0;
        for (int k = 1; k <= N + 4 && !got; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (k == 1) chk("sum_cleared_on_accept", 32'(sum), 32'(0));
            if (done) begin
                got = 1'b1;
                chk("done_latency", 32'(k), 32'(N + 1));
                rs = sum; rc = c_out; ro = overflow;
            end
            a    = W'($urandom);
            b    = W'($urandom);
            c_in = 1'($urandom);
            if (poke && k == 2) begin
                start = 1'b1;
                a     = 12'h123;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_seen", 32'(got), 32'(1));
        chk("busy_cycles", 32'(nbusy), 32'(N));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("idle_after_done", 32'(busy), 32'(0));
        chk("sum_held", 32'(sum), 32'(rs));
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        logic [W+1:0] m;
        logic         ts;

        vecs.push_back('{12'h007, 12'h001, 1'b0, 1'b0, 12'h008, 1'b0, 1'b0});
        vecs.push_back('{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0});
        vecs.push_back('{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1});
        vecs.push_back('{12'h001, 12'h002, 1'b1, 1'b0, 12'h004, 1'b0, 1'b0});
        vecs.push_back('{12'h000, 12'h000, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0});
        vecs.push_back('{12'hFFF, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0});
        vecs.push_back('{12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1});
        vecs.push_back('{12'h555, 12'h2AA, 1'b1, 1'b0, 12'h800, 1'b0, 1'b1});
`ifdef ADDER_SEQUENCER_SUB_EN
        vecs.push_back('{12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0});
        vecs.push_back('{12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1});
        vecs.push_back('{12'h123, 12'h123, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0});
`endif

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef ADDER_SEQUENCER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_sum", 32'(sum), 32'(0));
        chk("reset_c_out", 32'(c_out), 32'(0));
        chk("reset_overflow", 32'(overflow), 32'(0));
        rst = 1'b0;

        // Vector table
        foreach (vecs[i]) begin
`ifdef ADDER_SEQUENCER_SUB_EN
            sub = vecs[i].sub;
`endif
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, ro);
            chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].s));
            chk($sformatf("vec%0d_c_out", i), 32'(rc), 32'(vecs[i].co));
            chk($sformatf("vec%0d_overflow", i), 32'(ro), 32'(vecs[i].ov));
        end

        // Start pulsed during RUN with changed operands is ignored
        run_op(12'h007, 12'h001, 1'b0, 1'b1, rs, rc, ro);
        chk("poke_sum", 32'(rs), 32'h008);
        repeat (N + 2) begin
            @(negedge clk);
            chk("poke_no_second_run", 32'({busy, done}), 32'(0));
        end

        // Reset at the second RUN cycle aborts the add
        @(negedge clk);
        a = 12'hFFF; b = 12'hFFF; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_sum", 32'(sum), 32'(0));
        chk("abort_flags", 32'({c_out, overflow}), 32'(0));
        run_op(12'h001, 12'h002, 1'b1, 1'b0, rs, rc, ro);
        chk("after_abort_sum", 32'(rs), 32'h004);

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rci;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            ts  = 1'b0;
`ifdef ADDER_SEQUENCER_SUB_EN
            ts  = 1'($urandom);
            sub = ts;
`endif
            m = ref_add(ra, rb, rci, ts);
            run_op(ra, rb, rci, 1'b0, rs, rc, ro);
            chk($sformatf("rand%0d_result", i), 32'({ro, rc, rs}), 32'(m));
        end

        // start held high: accepts every N+2 cycles with the operands present
        begin
            logic [W-1:0] ca;
            logic [W-1:0] cb;
            logic         cc;
            logic         cs;
            logic [W+1:0] pend;
            bit           have_pend;
            logic         prev_busy;
            int           last_acc;
            int           n_acc;
            int           n_done;
            have_pend = 1'b0; prev_busy = 1'b0; last_acc = -1; n_acc = 0; n_done = 0;
            pend = '0;
            @(negedge clk);
            start = 1'b1;
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
            for (int cyc = 0; cyc < 4 * (N + 2) + 2; cyc++) begin
                @(negedge clk);
                ca = a; cb = b; cc = c_in; cs = 1'b0;
`ifdef ADDER_SEQUENCER_SUB_EN
                cs = sub;
`endif
                if (done) begin
                    n_done++;
                    chk("b2b_done_has_pending", 32'(have_pend), 32'(1));
                    chk("b2b_result", 32'({overflow, c_out, sum}), 32'(pend));
                    have_pend = 1'b0;
                end
                if (busy && !prev_busy) begin
                    n_acc++;
                    pend = ref_add(ca, cb, cc, cs);
                    have_pend = 1'b1;
                    if (last_acc >= 0) chk("b2b_interval", 32'(cyc - last_acc), 32'(N + 2));
                    last_acc = cyc;
                end
                prev_busy = busy;
                a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
`ifdef ADDER_SEQUENCER_SUB_EN
                sub = 1'($urandom);
`endif
            end
            start = 1'b0;
            chk("b2b_accepts", 32'(n_acc >= 4), 32'(1));
            chk("b2b_dones", 32'(n_done >= 3), 32'(1));
            repeat (N + 3) @(negedge clk);
            chk("b2b_idle", 32'({busy, done}), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
